multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle main decoder.
- Sequences one instruction over 3-5 states: fetch, decode, execute, memory, writeback.
- Drives the shared-ALU, single-memory datapath.
- Waits on a memory ready handshake, flags illegal opcodes and memory timeouts, and parks in a trap state.
- Sits between instruction register (opcode source) and datapath muxes/enables.

---
 rtl/multicycle_pkg.sv | 103 ++++++++++
 rtl/mem_wait_timer.sv | 54 +++++
 rtl/multicycle_control.sv | 208 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_pkg.sv
// Shared definitions for the multi-cycle control unit: state encoding,
// RV32 major opcodes, datapath mux encodings and the control word layout.
package multicycle_pkg;

    // ------------------------------------------------------------------
    // State encoding. Plain constants keep the encoding visible on the
    // state_o debug port and stable across tool versions.
    // ------------------------------------------------------------------
    localparam int STATE_W = 4;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_RST      = 4'd0;
    localparam state_t S_FETCH    = 4'd1;
    localparam state_t S_DECODE   = 4'd2;
    localparam state_t S_EXEC_R   = 4'd3;
    localparam state_t S_EXEC_I   = 4'd4;
    localparam state_t S_MEM_ADDR = 4'd5;
    localparam state_t S_MEM_RD   = 4'd6;
    localparam state_t S_MEM_WR   = 4'd7;
    localparam state_t S_WB_ALU   = 4'd8;
    localparam state_t S_WB_MEM   = 4'd9;
    localparam state_t S_BRANCH   = 4'd10;
    localparam state_t S_JAL      = 4'd11;
    localparam state_t S_JALR     = 4'd12;
    localparam state_t S_ILLEGAL  = 4'd13;

    // ------------------------------------------------------------------
    // Major opcodes (instruction[6:0]) understood by the sequencer.
    // ------------------------------------------------------------------
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // ------------------------------------------------------------------
    // Datapath mux / ALU encodings.
    // ------------------------------------------------------------------
    localparam logic [1:0] PC_SRC_ALU     = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT  = 2'b01;

    localparam logic [1:0] WB_SRC_ALUOUT  = 2'b00;
    localparam logic [1:0] WB_SRC_MDR     = 2'b01;
    localparam logic [1:0] WB_SRC_PC      = 2'b10;

    localparam logic [1:0] SRC_A_PC       = 2'b00;
    localparam logic [1:0] SRC_A_RS1      = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC   = 2'b10;

    localparam logic [1:0] SRC_B_RS2      = 2'b00;
    localparam logic [1:0] SRC_B_FOUR     = 2'b01;
    localparam logic [1:0] SRC_B_IMM      = 2'b10;

    localparam logic [1:0] ALU_OP_ADD     = 2'b00;
    localparam logic [1:0] ALU_OP_BRANCH  = 2'b01;
    localparam logic [1:0] ALU_OP_RFUNCT  = 2'b10;
    localparam logic [1:0] ALU_OP_IFUNCT  = 2'b11;

    // ------------------------------------------------------------------
    // Control word driven towards the datapath. Everything except the
    // sticky trap flags lives here so a single default clears it all.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic       pcWrite;
        logic [1:0] pcSrc;
        logic       irWrite;
        logic       iord;
        logic       memRead;
        logic       memWrite;
        logic [1:0] memToReg;
        logic [1:0] aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic       regWrite;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

    // Dispatch target for the state after DECODE. Jumps fall into the
    // illegal trap when the core is built without jump support.
    function automatic state_t dispatchOpcode(input logic [6:0] op,
                                              input logic       jumpEn);
        state_t target;
        case (op)
            OP_RTYPE:           target = S_EXEC_R;
            OP_ITYPE:           target = S_EXEC_I;
            OP_LOAD, OP_STORE:  target = S_MEM_ADDR;
            OP_BRANCH:          target = S_BRANCH;
            OP_JAL:             target = jumpEn ? S_JAL  : S_ILLEGAL;
            OP_JALR:            target = jumpEn ? S_JALR : S_ILLEGAL;
            default:            target = S_ILLEGAL;
        endcase
        return target;
    endfunction

    // States that sit on the memory handshake and may time out.
    function automatic logic isMemWaitState(input state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory access has been left waiting and
// raises timeout on the last permitted cycle. A MEM_TIMEOUT of zero turns
// the watchdog off entirely. CNT_W must be wide enough to hold
// MEM_TIMEOUT-1.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic waiting,
    input  logic mem_ready,
    output logic timeout
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int LIMIT_INT  = (MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(LIMIT_INT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             stalled;

    // A cycle only counts as stalled while the access is still unanswered;
    // mem_ready ends the access (and the state) so the count restarts.
    assign stalled = waiting && !mem_ready;

    // The compare looks at the count of stalls already seen, so the
    // MEM_TIMEOUT-th unanswered cycle is the one that trips the watchdog.
    assign timeout = TIMEOUT_EN && stalled && (count_q == LIMIT);

    // Next count: grow while stalled (saturating when the watchdog is off),
    // otherwise clear so every new state starts from zero.
    always_comb begin
        count_d = '0;
        if (stalled && !timeout) begin
            if (count_q == '1) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle main controller. Walks one instruction through fetch,
// decode, execute, memory and writeback states, drives the shared-ALU /
// single-memory datapath, and parks in a trap state on an illegal opcode
// or a memory handshake timeout.
module multicycle_control
    import multicycle_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter bit SUPPORT_JUMP = 1'b1,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    input  logic       branch_taken,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       ir_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic [1:0] mem_to_reg,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       trap,
    output logic       bus_error,
    output logic [3:0] state_o
);

    state_t state_q;
    state_t state_d;
    logic   trap_q;
    logic   bus_error_q;
    logic   memWaiting;
    logic   memTimeout;
    ctrl_t  ctrl;

    assign memWaiting = isMemWaitState(state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .waiting   (memWaiting),
        .mem_ready (mem_ready),
        .timeout   (memTimeout)
    );

    // Next-state sequencing. Handshake states hold until mem_ready, and a
    // watchdog expiry (only possible while mem_ready is low) diverts to the
    // trap. Unused encodings also trap so a corrupted state cannot drive
    // the datapath.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (memTimeout) begin
                    state_d = S_ILLEGAL;
                end
            end
            S_DECODE:   state_d = dispatchOpcode(opcode, SUPPORT_JUMP);
            S_EXEC_R:   state_d = S_WB_ALU;
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (memTimeout) begin
                    state_d = S_ILLEGAL;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                end else if (memTimeout) begin
                    state_d = S_ILLEGAL;
                end
            end
            S_WB_ALU:   state_d = S_FETCH;
            S_WB_MEM:   state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_FETCH;
            S_JALR:     state_d = S_FETCH;
            S_ILLEGAL:  state_d = S_ILLEGAL;
            default:    state_d = S_ILLEGAL;
        endcase
    end

    // State register plus the sticky trap flags; the flags rise together
    // with the entry into the trap state and only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RST;
            trap_q      <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ILLEGAL) begin
                trap_q <= 1'b1;
            end
            if (memTimeout) begin
                bus_error_q <= 1'b1;
            end
        end
    end

    // Control word decoded from the current state. Only the fetch write
    // enables and the branch PC write look at live inputs; everything else
    // is a pure function of state so a reset clears it immediately.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state_q)
            S_FETCH: begin
                ctrl.memRead = 1'b1;
                ctrl.iord    = 1'b0;
                ctrl.aluSrcA = SRC_A_PC;
                ctrl.aluSrcB = SRC_B_FOUR;
                ctrl.aluOp   = ALU_OP_ADD;
                ctrl.pcSrc   = PC_SRC_ALU;
                ctrl.irWrite = mem_ready;
                ctrl.pcWrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.aluSrcA = SRC_A_OLD_PC;
                ctrl.aluSrcB = SRC_B_IMM;
                ctrl.aluOp   = ALU_OP_ADD;
            end
            S_EXEC_R: begin
                ctrl.aluSrcA = SRC_A_RS1;
                ctrl.aluSrcB = SRC_B_RS2;
                ctrl.aluOp   = ALU_OP_RFUNCT;
            end
            S_EXEC_I: begin
                ctrl.aluSrcA = SRC_A_RS1;
                ctrl.aluSrcB = SRC_B_IMM;
                ctrl.aluOp   = ALU_OP_IFUNCT;
            end
            S_MEM_ADDR: begin
                ctrl.aluSrcA = SRC_A_RS1;
                ctrl.aluSrcB = SRC_B_IMM;
                ctrl.aluOp   = ALU_OP_ADD;
            end
            S_MEM_RD: begin
                ctrl.memRead = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_WB_ALU: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = WB_SRC_ALUOUT;
            end
            S_WB_MEM: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = WB_SRC_MDR;
            end
            S_BRANCH: begin
                ctrl.aluSrcA = SRC_A_RS1;
                ctrl.aluSrcB = SRC_B_RS2;
                ctrl.aluOp   = ALU_OP_BRANCH;
                ctrl.pcSrc   = PC_SRC_ALUOUT;
                ctrl.pcWrite = branch_taken;
            end
            S_JAL: begin
                ctrl.pcWrite  = 1'b1;
                ctrl.pcSrc    = PC_SRC_ALUOUT;
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = WB_SRC_PC;
            end
            S_JALR: begin
                ctrl.aluSrcA  = SRC_A_RS1;
                ctrl.aluSrcB  = SRC_B_IMM;
                ctrl.aluOp    = ALU_OP_ADD;
                ctrl.pcSrc    = PC_SRC_ALU;
                ctrl.pcWrite  = 1'b1;
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = WB_SRC_PC;
            end
            default: ctrl = CTRL_IDLE;
        endcase
    end

    assign pc_write   = ctrl.pcWrite;
    assign pc_src     = ctrl.pcSrc;
    assign ir_write   = ctrl.irWrite;
    assign iord       = ctrl.iord;
    assign mem_read   = ctrl.memRead;
    assign mem_write  = ctrl.memWrite;
    assign mem_to_reg = ctrl.memToReg;
    assign alu_src_a  = ctrl.aluSrcA;
    assign alu_src_b  = ctrl.aluSrcB;
    assign alu_op     = ctrl.aluOp;
    assign reg_write  = ctrl.regWrite;
    assign trap       = trap_q;
    assign bus_error  = bus_error_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control: table of per-instruction counts,
// hand-written corner sequences and a randomized run against an
// instruction-level reference model.
module tb_multicycle_control;
    import multicycle_pkg::*;

    localparam int TB_TIMEOUT = 4;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    logic       pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic       trap, bus_error;
    logic [1:0] pc_src, mem_to_reg, alu_src_a, alu_src_b, alu_op;
    logic [3:0] state_o;

    logic       pc_write2, ir_write2, iord2, mem_read2, mem_write2, reg_write2;
    logic       trap2, bus_error2;
    logic [1:0] pc_src2, mem_to_reg2, alu_src_a2, alu_src_b2, alu_op2;
    logic [3:0] state_o2;

    logic [15:0] ctrlNow;

    int checks = 0;
    int errors = 0;

    multicycle_control #(
        .MEM_TIMEOUT (TB_TIMEOUT),
        .SUPPORT_JUMP(1'b1),
        .CNT_W       (8)
    ) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write), .pc_src(pc_src),
        .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write),
        .trap(trap), .bus_error(bus_error), .state_o(state_o)
    );

    multicycle_control #(
        .MEM_TIMEOUT (0),
        .SUPPORT_JUMP(1'b0),
        .CNT_W       (8)
    ) dutNoJump (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .pc_write(pc_write2), .pc_src(pc_src2),
        .ir_write(ir_write2), .iord(iord2), .mem_read(mem_read2),
        .mem_write(mem_write2), .mem_to_reg(mem_to_reg2), .alu_src_a(alu_src_a2),
        .alu_src_b(alu_src_b2), .alu_op(alu_op2), .reg_write(reg_write2),
        .trap(trap2), .bus_error(bus_error2), .state_o(state_o2)
    );

    assign ctrlNow = {pc_write, pc_src, ir_write, iord, mem_read, mem_write,
                      mem_to_reg, alu_src_a, alu_src_b, alu_op, reg_write};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- helpers ----------------
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and settle.
    task automatic applyStimulus(input logic [6:0] op, input logic rdy,
                                 input logic bt);
        @(negedge clk);
        opcode       = op;
        mem_ready    = rdy;
        branch_taken = bt;
        #1;
    endtask

    task automatic doReset();
        @(negedge clk);
        rst       = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- reference model ----------------
    typedef enum {K_RST, K_FETCH, K_DECODE, K_EXEC_R, K_EXEC_I, K_MEM_ADDR,
                  K_MEM_RD, K_MEM_WR, K_WB_ALU, K_WB_MEM, K_BRANCH, K_JAL,
                  K_JALR, K_ILLEGAL} step_e;

    step_e script[$];
    step_e cur;
    int    idx, waitCnt, illegalCnt, readyBias;
    bit    mTrap, mBus, needNew, resetNow;

    function automatic logic [15:0] mk(input logic pcw, input logic [1:0] pcs,
        input logic irw, input logic io, input logic mr, input logic mw,
        input logic [1:0] m2r, input logic [1:0] a, input logic [1:0] b,
        input logic [1:0] op, input logic rw);
        return {pcw, pcs, irw, io, mr, mw, m2r, a, b, op, rw};
    endfunction

    function automatic logic [15:0] expectCtrl(input step_e s, input logic rdy,
                                               input logic bt);
        case (s)
            K_FETCH:    return mk(rdy, 2'd0, rdy, 0, 1, 0, 2'd0, 2'd0, 2'd1, 2'd0, 0);
            K_DECODE:   return mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd2, 2'd0, 0);
            K_EXEC_R:   return mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd2, 0);
            K_EXEC_I:   return mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd3, 0);
            K_MEM_ADDR: return mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd0, 0);
            K_MEM_RD:   return mk(0, 2'd0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0, 2'd0, 0);
            K_MEM_WR:   return mk(0, 2'd0, 0, 1, 0, 1, 2'd0, 2'd0, 2'd0, 2'd0, 0);
            K_WB_ALU:   return mk(0, 2'd0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 1);
            K_WB_MEM:   return mk(0, 2'd0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0, 2'd0, 1);
            K_BRANCH:   return mk(bt, 2'd1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 2'd1, 0);
            K_JAL:      return mk(1, 2'd1, 0, 0, 0, 0, 2'd2, 2'd0, 2'd0, 2'd0, 1);
            K_JALR:     return mk(1, 2'd0, 0, 0, 0, 0, 2'd2, 2'd1, 2'd2, 2'd0, 1);
            default:    return 16'd0;
        endcase
    endfunction

    function automatic logic [3:0] stepState(input step_e s);
        case (s)
            K_FETCH:    return S_FETCH;
            K_DECODE:   return S_DECODE;
            K_EXEC_R:   return S_EXEC_R;
            K_EXEC_I:   return S_EXEC_I;
            K_MEM_ADDR: return S_MEM_ADDR;
            K_MEM_RD:   return S_MEM_RD;
            K_MEM_WR:   return S_MEM_WR;
            K_WB_ALU:   return S_WB_ALU;
            K_WB_MEM:   return S_WB_MEM;
            K_BRANCH:   return S_BRANCH;
            K_JAL:      return S_JAL;
            K_JALR:     return S_JALR;
            K_ILLEGAL:  return S_ILLEGAL;
            default:    return S_RST;
        endcase
    endfunction

    // Steps an instruction takes, straight from its opcode class.
    task automatic buildScript(input logic [6:0] op);
        script.delete();
        script.push_back(K_FETCH);
        script.push_back(K_DECODE);
        case (op)
            7'b0110011: begin script.push_back(K_EXEC_R); script.push_back(K_WB_ALU); end
            7'b0010011: begin script.push_back(K_EXEC_I); script.push_back(K_WB_ALU); end
            7'b0000011: begin script.push_back(K_MEM_ADDR); script.push_back(K_MEM_RD);
                              script.push_back(K_WB_MEM); end
            7'b0100011: begin script.push_back(K_MEM_ADDR); script.push_back(K_MEM_WR); end
            7'b1100011: script.push_back(K_BRANCH);
            7'b1101111: script.push_back(K_JAL);
            7'b1100111: script.push_back(K_JALR);
            default:    script.push_back(K_ILLEGAL);
        endcase
    endtask

    task automatic advanceModel();
        case (cur)
            K_RST: begin
                cur = K_FETCH; idx = 0; waitCnt = 0; needNew = 1;
            end
            K_ILLEGAL: begin
                illegalCnt++;
                if (illegalCnt >= 3) resetNow = 1;
            end
            default: begin
                if ((cur == K_FETCH || cur == K_MEM_RD || cur == K_MEM_WR) && !mem_ready) begin
                    waitCnt++;
                    if (waitCnt == TB_TIMEOUT) begin
                        cur = K_ILLEGAL; mTrap = 1; mBus = 1;
                    end
                end else begin
                    waitCnt = 0;
                    idx++;
                    if (idx >= script.size()) begin
                        cur = K_FETCH; idx = 0; needNew = 1;
                    end else begin
                        cur = script[idx];
                        if (cur == K_ILLEGAL) mTrap = 1;
                    end
                end
            end
        endcase
    endtask

    task automatic compareModel();
        checkOutput("random", {10'd0, state_o, trap, bus_error, ctrlNow},
                    {10'd0, stepState(cur), mTrap, mBus,
                     expectCtrl(cur, mem_ready, branch_taken)});
    endtask

    // ---------------- table ----------------
    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         expLat;
        int         expRegW;
        int         expPcW;
        int         expMemW;
    } vec_t;

    vec_t vecs[8];

    task automatic runVector(input vec_t v, input int n);
        int cycles = 0, rw = 0, pw = 0, mw = 0;
        do begin
            applyStimulus(v.op, 1'b1, v.bt);
            rw += int'(reg_write);
            pw += int'(pc_write);
            mw += int'(mem_write);
            cycles++;
            @(posedge clk);
            #1;
        end while (state_o != S_FETCH && state_o != S_ILLEGAL && cycles < 20);
        checkOutput($sformatf("vec%0d latency", n), cycles, v.expLat);
        checkOutput($sformatf("vec%0d reg_write", n), rw, v.expRegW);
        checkOutput($sformatf("vec%0d pc_write", n), pw, v.expPcW);
        checkOutput($sformatf("vec%0d mem_write", n), mw, v.expMemW);
    endtask

    logic [6:0] legalOps [7];

    // ---------------- main test ----------------
    initial begin
        logic [3:0] rSeq [4];
        logic       rRw  [4];
        logic       rIrw [4];
        logic [6:0] op;
        int         sel;

        vecs[0] = '{7'b0110011, 1'b0, 4, 1, 1, 0};
        vecs[1] = '{7'b0010011, 1'b0, 4, 1, 1, 0};
        vecs[2] = '{7'b0000011, 1'b0, 5, 1, 1, 0};
        vecs[3] = '{7'b0100011, 1'b0, 4, 0, 1, 1};
        vecs[4] = '{7'b1100011, 1'b1, 3, 0, 2, 0};
        vecs[5] = '{7'b1100011, 1'b0, 3, 0, 1, 0};
        vecs[6] = '{7'b1101111, 1'b0, 3, 1, 2, 0};
        vecs[7] = '{7'b1100111, 1'b1, 3, 1, 2, 0};
        legalOps = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                     7'b1100011, 7'b1101111, 7'b1100111};

        rst = 1'b1; opcode = 7'd0; mem_ready = 1'b0; branch_taken = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        checkOutput("reset state", state_o, S_RST);
        checkOutput("reset ctrl", ctrlNow, 16'd0);
        checkOutput("reset trap", {trap, bus_error}, 2'b00);
        rst = 1'b0;

        // R-type cycle by cycle with mem_ready high
        rSeq = '{S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU};
        rRw  = '{1'b0, 1'b0, 1'b0, 1'b1};
        rIrw = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7'b0110011, 1'b1, 1'b0);
            checkOutput($sformatf("rtype state c%0d", i + 1), state_o, rSeq[i]);
            checkOutput($sformatf("rtype reg_write c%0d", i + 1), reg_write, rRw[i]);
            checkOutput($sformatf("rtype ir_write c%0d", i + 1), ir_write, rIrw[i]);
        end

        // Table of per-instruction latency and enable counts
        for (int i = 0; i < 8; i++) runVector(vecs[i], i);

        // JAL with and without jump support
        doReset();
        applyStimulus(7'b1101111, 1'b1, 1'b0);
        applyStimulus(7'b1101111, 1'b1, 1'b0);
        applyStimulus(7'b1101111, 1'b1, 1'b0);
        checkOutput("jal state", state_o, S_JAL);
        checkOutput("jal enables", {pc_write, pc_src, reg_write, mem_to_reg},
                    {1'b1, 2'b01, 1'b1, 2'b10});
        checkOutput("nojump state", state_o2, S_ILLEGAL);
        checkOutput("nojump trap", {trap2, bus_error2}, 2'b10);

        // Load with three wait cycles in the memory read
        doReset();
        applyStimulus(7'b0000011, 1'b1, 1'b0);
        applyStimulus(7'b0000011, 1'b1, 1'b0);
        applyStimulus(7'b0000011, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(7'b0000011, (i == 3), 1'b0);
            checkOutput($sformatf("load wait c%0d", i + 1),
                        {state_o, mem_read, iord}, {S_MEM_RD, 2'b11});
        end
        applyStimulus(7'b0000011, 1'b1, 1'b0);
        checkOutput("load wb", {state_o, reg_write, mem_to_reg},
                    {S_WB_MEM, 1'b1, 2'b01});

        // Fetch timeout
        doReset();
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            applyStimulus(7'b0110011, 1'b0, 1'b0);
            checkOutput($sformatf("timeout fetch c%0d", i + 1),
                        {state_o, mem_read}, {S_FETCH, 1'b1});
        end
        applyStimulus(7'b0110011, 1'b0, 1'b0);
        checkOutput("timeout state", state_o, S_ILLEGAL);
        checkOutput("timeout flags", {trap, bus_error}, 2'b11);
        checkOutput("timeout ctrl", ctrlNow, 16'd0);

        // Ready on the last permitted cycle wins over the timeout
        doReset();
        for (int i = 0; i < TB_TIMEOUT; i++) begin
            applyStimulus(7'b0110011, (i == TB_TIMEOUT - 1), 1'b0);
        end
        checkOutput("late ready ir_write", ir_write, 1'b1);
        applyStimulus(7'b0110011, 1'b1, 1'b0);
        checkOutput("late ready state", state_o, S_DECODE);
        checkOutput("late ready flags", {trap, bus_error}, 2'b00);

        // Reset asserted during a store
        doReset();
        applyStimulus(7'b0100011, 1'b1, 1'b0);
        applyStimulus(7'b0100011, 1'b1, 1'b0);
        applyStimulus(7'b0100011, 1'b1, 1'b0);
        applyStimulus(7'b0100011, 1'b0, 1'b0);
        checkOutput("store write", {state_o, mem_write}, {S_MEM_WR, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midreset outputs", {state_o, trap, bus_error, ctrlNow},
                    {S_RST, 18'd0});
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(7'b0100011, 1'b1, 1'b0);
        checkOutput("midreset fetch", state_o, S_FETCH);

        // Randomized run against the instruction-level model
        doReset();
        cur = K_FETCH; idx = 0; waitCnt = 0; illegalCnt = 0;
        mTrap = 0; mBus = 0; needNew = 1; resetNow = 0; readyBias = 7;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (resetNow) begin
                rst = 1'b1;
                resetNow = 0; needNew = 0;
                cur = K_RST; mTrap = 0; mBus = 0; waitCnt = 0; illegalCnt = 0;
                mem_ready = 1'($urandom_range(0, 1));
                #1;
                compareModel();
                continue;
            end
            rst = 1'b0;
            if (needNew) begin
                sel = $urandom_range(0, 8);
                op  = (sel < 7) ? legalOps[sel] : 7'($urandom_range(0, 127));
                opcode = op;
                buildScript(op);
                idx = 0; needNew = 0;
                readyBias = $urandom_range(3, 9);
            end
            mem_ready    = ($urandom_range(0, 9) < readyBias);
            branch_taken = 1'($urandom_range(0, 1));
            #1;
            compareModel();
            advanceModel();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
